// File: rtl/macc_operand_feeder.sv
// Operand feeder for the MACC: FIFO-buffered pairs, registered issue,
// burst framing with acc_clear and a latency-matched burst_done pulse.
module macc_operand_feeder #(
    parameter int A_WIDTH  = 25,
    parameter int B_WIDTH  = 18,
    parameter int DEPTH    = 4,
    parameter int MACC_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         in_a,
    input  logic [B_WIDTH-1:0]         in_b,
    input  logic                       in_carry,
    input  logic                       in_last,
    input  logic                       hold,
    output logic [A_WIDTH-1:0]         a_out,
    output logic [B_WIDTH-1:0]         b_out,
    output logic                       carryin_out,
    output logic                       op_valid,
    output logic                       acc_clear,
    output logic                       burst_done,
    output logic [7:0]                 burst_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = $clog2(MACC_LAT + 1);
    localparam int EW = A_WIDTH + B_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] cnt;
    logic [FW-1:0] flush_cnt;

    logic push, pop, clear_d, done_d, flush_end;
    logic [EW-1:0] head;
    logic [A_WIDTH-1:0] head_a;
    logic [B_WIDTH-1:0] head_b;
    logic head_carry, head_last;

    assign in_ready = rst && (cnt != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign level    = cnt;

    assign head       = mem[rd_ptr];
    assign head_a     = head[EW-1 -: A_WIDTH];
    assign head_b     = head[B_WIDTH+1:2];
    assign head_carry = head[1];
    assign head_last  = head[0];

    assign flush_end = (flush_cnt == FW'(MACC_LAT));

    // Storage holds no reset: emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_carry, in_last};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (pop) state_nx = head_last ? FLUSH : RUN;
            end
            RUN: begin
                if (pop && head_last) state_nx = FLUSH;
            end
            FLUSH: begin
                if (flush_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        pop     = 1'b0;
        clear_d = 1'b0;
        done_d  = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                pop     = (cnt != '0) && !hold;
                clear_d = pop;
            end
            (state == RUN): begin
                pop = (cnt != '0) && !hold;
            end
            (state == FLUSH): begin
                done_d = flush_end;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // flush_cnt is 0 in the cycle the last pair is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (state == FLUSH && !flush_end) begin
            flush_cnt <= flush_cnt + 1'b1;
        end else begin
            flush_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out       <= '0;
            b_out       <= '0;
            carryin_out <= 1'b0;
            op_valid    <= 1'b0;
            acc_clear   <= 1'b0;
        end else if (pop) begin
            a_out       <= head_a;
            b_out       <= head_b;
            carryin_out <= head_carry;
            op_valid    <= 1'b1;
            acc_clear   <= clear_d;
        end else begin
            a_out       <= '0;
            b_out       <= '0;
            carryin_out <= 1'b0;
            op_valid    <= 1'b0;
            acc_clear   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_done <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            burst_done <= done_d;
            if (done_d) burst_cnt <= burst_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_macc_operand_feeder.sv
// Directed testbench for macc_operand_feeder.
// Each scenario task checks its own expectations inline.
module tb_macc_operand_feeder;

    localparam int AW = 25;
    localparam int BW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic          in_carry;
    logic          in_last;
    logic          hold;
    logic [AW-1:0] a_out;
    logic [BW-1:0] b_out;
    logic          carryin_out;
    logic          op_valid;
    logic          acc_clear;
    logic          burst_done;
    logic [7:0]    burst_cnt;
    logic [2:0]    level;

    int pass_cnt = 0;
    int total    = 0;

    macc_operand_feeder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .in_carry(in_carry), .in_last(in_last),
        .hold(hold),
        .a_out(a_out), .b_out(b_out),
        .carryin_out(carryin_out),
        .op_valid(op_valid), .acc_clear(acc_clear),
        .burst_done(burst_done), .burst_cnt(burst_cnt),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b,
                         input logic c, input logic l);
        in_valid = v;
        in_a     = AW'(a);
        in_b     = BW'(b);
        in_carry = c;
        in_last  = l;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b0)
            $display("FAIL rst_ready got %0d exp 0", in_ready);
        else pass_cnt++;
        total++; if (op_valid !== 1'b0)
            $display("FAIL rst_valid got %0d exp 0", op_valid);
        else pass_cnt++;
        total++; if (level !== 3'd0)
            $display("FAIL rst_level got %0d exp 0", level);
        else pass_cnt++;
        total++; if (burst_cnt !== 8'd0)
            $display("FAIL rst_bcnt got %0d exp 0", burst_cnt);
        else pass_cnt++;
        total++; if (a_out !== '0 || b_out !== '0 || burst_done !== 1'b0)
            $display("FAIL rst_outs got a=%0d b=%0d d=%0d exp 0",
                     a_out, b_out, burst_done);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1)
            $display("FAIL rel_ready got %0d exp 1", in_ready);
        else pass_cnt++;
        step();
    endtask

    task automatic test_single();
        drive(1, 38, 22, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        total++; if (level !== 3'd1 || op_valid !== 1'b0)
            $display("FAIL single_nobypass got lvl=%0d v=%0d exp 1/0",
                     level, op_valid);
        else pass_cnt++;
        step();
        total++;
        if (a_out !== 38 || b_out !== 22 || carryin_out !== 1'b1 ||
            op_valid !== 1'b1 || acc_clear !== 1'b1)
            $display("FAIL single_issue got a=%0d b=%0d c=%0d v=%0d clr=%0d exp 38/22/1/1/1",
                     a_out, b_out, carryin_out, op_valid, acc_clear);
        else pass_cnt++;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                total++;
                if (op_valid !== 1'b0 || a_out !== '0 || acc_clear !== 1'b0)
                    $display("FAIL single_zero got v=%0d a=%0d exp 0",
                             op_valid, a_out);
                else pass_cnt++;
            end
            total++; if (burst_done !== (k == 4))
                $display("FAIL single_done k=%0d got %0d exp %0d",
                         k, burst_done, (k == 4));
            else pass_cnt++;
        end
        total++; if (burst_cnt !== 8'd1)
            $display("FAIL single_bcnt got %0d exp 1", burst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ea [4] = '{33, 1, 2, 3};
        int eb [4] = '{12, 1, 2, 3};
        int dn = 0;
        int at = 0;
        drive(1, ea[0], eb[0], 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1, ea[i+1], eb[i+1], 0, (i + 1) == 3);
            else       drive(0, 0, 0, 0, 0);
            step();
            total++;
            if (a_out !== AW'(ea[i]) || b_out !== BW'(eb[i]) ||
                op_valid !== 1'b1 || acc_clear !== (i == 0))
                $display("FAIL b2b_pair%0d got a=%0d b=%0d v=%0d clr=%0d exp %0d/%0d/1/%0d",
                         i, a_out, b_out, op_valid, acc_clear,
                         ea[i], eb[i], (i == 0));
            else pass_cnt++;
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            if (burst_done) begin dn++; at = k; end
        end
        total++; if (dn != 1 || at != 4)
            $display("FAIL b2b_done got n=%0d at=%0d exp 1/4", dn, at);
        else pass_cnt++;
        total++; if (burst_cnt !== 8'd2)
            $display("FAIL b2b_bcnt got %0d exp 2", burst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_full();
        int idx = 0;
        int dn = 0;
        int at = 0;
        logic rdy;
        hold = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(1, 10 + idx, 20 + idx, 0, idx == 4);
            rdy = in_ready;
            step();
            if (rdy) idx++;
        end
        total++;
        if (level !== 3'd4 || in_ready !== 1'b0 || idx != 4 || op_valid !== 1'b0)
            $display("FAIL full_state got lvl=%0d rdy=%0d n=%0d v=%0d exp 4/0/4/0",
                     level, in_ready, idx, op_valid);
        else pass_cnt++;
        hold = 1'b0;
        step();
        total++;
        if (a_out !== 10 || acc_clear !== 1'b1 || level !== 3'd3 || in_ready !== 1'b1)
            $display("FAIL full_first got a=%0d clr=%0d lvl=%0d rdy=%0d exp 10/1/3/1",
                     a_out, acc_clear, level, in_ready);
        else pass_cnt++;
        step();
        drive(0, 0, 0, 0, 0);
        total++; if (a_out !== 11 || level !== 3'd3)
            $display("FAIL full_fifth got a=%0d lvl=%0d exp 11/3", a_out, level);
        else pass_cnt++;
        for (int i = 2; i <= 4; i++) begin
            step();
            total++;
            if (a_out !== AW'(10 + i) || b_out !== BW'(20 + i) ||
                op_valid !== 1'b1 || acc_clear !== 1'b0)
                $display("FAIL full_order%0d got a=%0d b=%0d v=%0d clr=%0d exp %0d/%0d/1/0",
                         i, a_out, b_out, op_valid, acc_clear, 10 + i, 20 + i);
            else pass_cnt++;
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            if (burst_done) begin dn++; at = k; end
        end
        total++; if (dn != 1 || at != 4 || burst_cnt !== 8'd3)
            $display("FAIL full_done got n=%0d at=%0d cnt=%0d exp 1/4/3",
                     dn, at, burst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int dn = 0;
        int at = 0;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 50 + i, 60 + i, 0, i == 3);
            step();
        end
        drive(0, 0, 0, 0, 0);
        hold = 1'b0;
        step();
        total++; if (a_out !== 50 || acc_clear !== 1'b1)
            $display("FAIL stall_p0 got a=%0d clr=%0d exp 50/1", a_out, acc_clear);
        else pass_cnt++;
        step();
        total++; if (a_out !== 51 || acc_clear !== 1'b0)
            $display("FAIL stall_p1 got a=%0d clr=%0d exp 51/0", a_out, acc_clear);
        else pass_cnt++;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (op_valid !== 1'b0 || a_out !== '0 || b_out !== '0 ||
                acc_clear !== 1'b0 || burst_done !== 1'b0)
                $display("FAIL stall_hold%0d got v=%0d a=%0d clr=%0d d=%0d exp 0",
                         k, op_valid, a_out, acc_clear, burst_done);
            else pass_cnt++;
        end
        hold = 1'b0;
        for (int i = 2; i < 4; i++) begin
            step();
            total++;
            if (a_out !== AW'(50 + i) || op_valid !== 1'b1 || acc_clear !== 1'b0)
                $display("FAIL stall_p%0d got a=%0d v=%0d clr=%0d exp %0d/1/0",
                         i, a_out, op_valid, acc_clear, 50 + i);
            else pass_cnt++;
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            if (burst_done) begin dn++; at = k; end
        end
        total++; if (dn != 1 || at != 4 || burst_cnt !== 8'd4)
            $display("FAIL stall_done got n=%0d at=%0d cnt=%0d exp 1/4/4",
                     dn, at, burst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int dn = 0;
        int at = 0;
        drive(1, 70, 80, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        total++; if (a_out !== 70 || acc_clear !== 1'b1)
            $display("FAIL flush_q0 got a=%0d clr=%0d exp 70/1", a_out, acc_clear);
        else pass_cnt++;
        drive(1, 5, 6, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        total++; if (op_valid !== 1'b0 || level !== 3'd1)
            $display("FAIL flush_push got v=%0d lvl=%0d exp 0/1", op_valid, level);
        else pass_cnt++;
        for (int k = 2; k <= 4; k++) begin
            step();
            total++;
            if (op_valid !== 1'b0 || burst_done !== (k == 4))
                $display("FAIL flush_wait%0d got v=%0d d=%0d exp 0/%0d",
                         k, op_valid, burst_done, (k == 4));
            else pass_cnt++;
        end
        total++; if (burst_cnt !== 8'd5)
            $display("FAIL flush_bcnt got %0d exp 5", burst_cnt);
        else pass_cnt++;
        step();
        total++;
        if (a_out !== 5 || b_out !== 6 || op_valid !== 1'b1 ||
            acc_clear !== 1'b1 || burst_done !== 1'b0)
            $display("FAIL flush_q1 got a=%0d b=%0d v=%0d clr=%0d d=%0d exp 5/6/1/1/0",
                     a_out, b_out, op_valid, acc_clear, burst_done);
        else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (burst_done) begin dn++; at = k; end
        end
        total++; if (dn != 1 || at != 4 || burst_cnt !== 8'd6)
            $display("FAIL flush_done got n=%0d at=%0d cnt=%0d exp 1/4/6",
                     dn, at, burst_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        int at = 0;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 90 + i, 95 + i, 1, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        hold = 1'b0;
        step();
        total++; if (a_out !== 90 || op_valid !== 1'b1 || level !== 3'd2)
            $display("FAIL rmid_run got a=%0d v=%0d lvl=%0d exp 90/1/2",
                     a_out, op_valid, level);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total++;
        if (a_out !== '0 || b_out !== '0 || carryin_out !== 1'b0 ||
            op_valid !== 1'b0 || acc_clear !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rmid_outs got a=%0d v=%0d c=%0d rdy=%0d exp 0",
                     a_out, op_valid, carryin_out, in_ready);
        else pass_cnt++;
        total++; if (level !== 3'd0 || burst_cnt !== 8'd0)
            $display("FAIL rmid_state got lvl=%0d cnt=%0d exp 0/0", level, burst_cnt);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            step();
            if (burst_done) dn++;
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (burst_done) dn++;
        end
        total++; if (dn != 0 || burst_cnt !== 8'd0)
            $display("FAIL rmid_nodone got n=%0d cnt=%0d exp 0/0", dn, burst_cnt);
        else pass_cnt++;
        drive(1, 7, 9, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        total++;
        if (a_out !== 7 || b_out !== 9 || carryin_out !== 1'b1 || acc_clear !== 1'b1)
            $display("FAIL rmid_new got a=%0d b=%0d c=%0d clr=%0d exp 7/9/1/1",
                     a_out, b_out, carryin_out, acc_clear);
        else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (burst_done) begin dn++; at = k; end
        end
        total++; if (dn != 1 || at != 4 || burst_cnt !== 8'd1)
            $display("FAIL rmid_done got n=%0d at=%0d cnt=%0d exp 1/4/1",
                     dn, at, burst_cnt);
        else pass_cnt++;
    endtask

    initial begin
        rst  = 1'b0;
        hold = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
